// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU controller: state encoding,
// instruction field constants, mux-select codes and the decode helper.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH       = 4'd0,
        S_FETCH_LATCH = 4'd1,
        S_DECODE      = 4'd2,
        S_EXEC_R      = 4'd3,
        S_EXEC_I      = 4'd4,
        S_WB_ALU      = 4'd5,
        S_WB_MOV      = 4'd6,
        S_LD_ADDR     = 4'd7,
        S_LD_WB       = 4'd8,
        S_ST          = 4'd9,
        S_BR          = 4'd10,
        S_JMP         = 4'd11,
        S_ILL         = 4'd12,
        S_PC_INC      = 4'd13
    } state_e;

    localparam logic [3:0] OP_RTYPE   = 4'b0000;
    localparam logic [3:0] OP_ANDI    = 4'b0001;
    localparam logic [3:0] OP_ORI     = 4'b0010;
    localparam logic [3:0] OP_XORI    = 4'b0011;
    localparam logic [3:0] OP_SPECIAL = 4'b0100;
    localparam logic [3:0] OP_ADDI    = 4'b0101;
    localparam logic [3:0] OP_SUBI    = 4'b1001;
    localparam logic [3:0] OP_CMPI    = 4'b1011;
    localparam logic [3:0] OP_BCOND   = 4'b1100;
    localparam logic [3:0] OP_MOVI    = 4'b1101;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_CMP   = 4'b1011;
    localparam logic [3:0] EXT_JCOND = 4'b1100;
    localparam logic [3:0] EXT_MOV   = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_HI = 4'b0100;
    localparam logic [3:0] COND_LS = 4'b0101;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_LO = 4'b1010;
    localparam logic [3:0] COND_HS = 4'b1011;
    localparam logic [3:0] COND_LT = 4'b1100;
    localparam logic [3:0] COND_GE = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // PSR bit positions, {N,Z,F,L,C}
    localparam int PSR_N = 4;
    localparam int PSR_Z = 3;
    localparam int PSR_F = 2;
    localparam int PSR_L = 1;
    localparam int PSR_C = 0;

    localparam logic       MEM_S_RDEST = 1'b0;
    localparam logic       MEM_S_PC    = 1'b1;
    localparam logic       PC_S_RSRC   = 1'b0;
    localparam logic       PC_S_ALU    = 1'b1;
    localparam logic [1:0] WD_IMM      = 2'd0;
    localparam logic [1:0] WD_RSRC     = 2'd1;
    localparam logic [1:0] WD_MEM      = 2'd2;
    localparam logic [1:0] WD_ALU      = 2'd3;
    localparam logic [1:0] ALUA_RSRC   = 2'd0;
    localparam logic [1:0] ALUA_PC     = 2'd1;
    localparam logic [1:0] ALUA_IMM    = 2'd2;
    localparam logic [1:0] ALUB_RDEST  = 2'd0;
    localparam logic [1:0] ALUB_IMM    = 2'd1;
    localparam logic [1:0] ALUB_ONE    = 2'd2;

    function automatic state_e decode_next(input logic [3:0] op, input logic [3:0] ext);
        state_e nxt;
        nxt = S_ILL;
        case (op)
            OP_RTYPE:   nxt = (ext == EXT_MOV) ? S_WB_MOV : S_EXEC_R;
            OP_ADDI, OP_SUBI, OP_CMPI,
            OP_ANDI, OP_ORI, OP_XORI: nxt = S_EXEC_I;
            OP_MOVI:    nxt = S_WB_MOV;
            OP_BCOND:   nxt = S_BR;
            OP_SPECIAL: begin
                case (ext)
                    EXT_LOAD:  nxt = S_LD_ADDR;
                    EXT_STOR:  nxt = S_ST;
                    EXT_JCOND: nxt = S_JMP;
                    default:   nxt = S_ILL;
                endcase
            end
            default:    nxt = S_ILL;
        endcase
        return nxt;
    endfunction

    function automatic logic imm_is_signed(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI);
    endfunction

endpackage

// File: rtl/mcycle_controller_cond_check.sv
// Branch/jump condition evaluator: maps a 4-bit condition code and the
// registered flags to a single taken bit.
module cond_check
    import cpu_ctrl_pkg::*;
#(
    parameter int PSRL = 5
) (
    input  logic [3:0]      cond,
    input  logic [PSRL-1:0] psr,
    output logic            taken
);

    logic n_f, z_f, f_f, l_f, c_f;

    assign n_f = psr[PSR_N];
    assign z_f = psr[PSR_Z];
    assign f_f = psr[PSR_F];
    assign l_f = psr[PSR_L];
    assign c_f = psr[PSR_C];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z_f;
            COND_NE: taken = !z_f;
            COND_CS: taken = c_f;
            COND_CC: taken = !c_f;
            COND_HI: taken = l_f;
            COND_LS: taken = !l_f;
            COND_GT: taken = n_f;
            COND_LE: taken = !n_f;
            COND_FS: taken = f_f;
            COND_FC: taken = !f_f;
            COND_LO: taken = !l_f && !z_f;
            COND_HS: taken = l_f || z_f;
            COND_LT: taken = !n_f && !z_f;
            COND_GE: taken = n_f || z_f;
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mcycle_controller.sv
// Multicycle control FSM: sequences each instruction through fetch, decode,
// execute, memory and write-back, driving all datapath selects and strobes.
module mcycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int PSRL = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      OP_CODE,
    input  logic [3:0]      OP_EXT,
    input  logic [3:0]      COND,
    input  logic [PSRL-1:0] PSR_OUT,
    output logic            PC_S,
    output logic            MEM_S,
    output logic [1:0]      WD_S,
    output logic [1:0]      ALUA_S,
    output logic [1:0]      ALUB_S,
    output logic            INSTR_EN,
    output logic            ALU_OUT_EN,
    output logic            MEM_REG_EN,
    output logic            PC_EN,
    output logic            PSR_EN,
    output logic            SE_SIGN,
    output logic            REG_WR,
    output logic            MEM_WE,
    output logic            FORCE_ADD,
    output logic            ILLEGAL
);

    state_e     state_q, state_d;
    logic [3:0] op_code_q, op_code_d;
    logic [3:0] op_ext_q, op_ext_d;
    logic [3:0] cond_q, cond_d;
    logic       taken;

    cond_check #(.PSRL(PSRL)) u_cond_check (
        .cond  (cond_q),
        .psr   (PSR_OUT),
        .taken (taken)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            op_code_q <= '0;
            op_ext_q  <= '0;
            cond_q    <= '0;
        end else begin
            state_q   <= state_d;
            op_code_q <= op_code_d;
            op_ext_q  <= op_ext_d;
            cond_q    <= cond_d;
        end
    end

    // Fields are held from DECODE onward so later states never see a changed IR.
    always_comb begin
        op_code_d = op_code_q;
        op_ext_d  = op_ext_q;
        cond_d    = cond_q;
        if (state_q == S_DECODE) begin
            op_code_d = OP_CODE;
            op_ext_d  = OP_EXT;
            cond_d    = COND;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:       state_d = S_FETCH_LATCH;
            S_FETCH_LATCH: state_d = S_DECODE;
            S_DECODE:      state_d = decode_next(OP_CODE, OP_EXT);
            S_EXEC_R:      state_d = (op_ext_q == EXT_CMP) ? S_PC_INC : S_WB_ALU;
            S_EXEC_I:      state_d = (op_code_q == OP_CMPI) ? S_PC_INC : S_WB_ALU;
            S_WB_ALU:      state_d = S_PC_INC;
            S_WB_MOV:      state_d = S_PC_INC;
            S_LD_ADDR:     state_d = S_LD_WB;
            S_LD_WB:       state_d = S_PC_INC;
            S_ST:          state_d = S_PC_INC;
            S_BR:          state_d = taken ? S_FETCH : S_PC_INC;
            S_JMP:         state_d = taken ? S_FETCH : S_PC_INC;
            S_ILL:         state_d = S_PC_INC;
            S_PC_INC:      state_d = S_FETCH;
            default:       state_d = S_FETCH;
        endcase
    end

    // Outputs are forced low for the whole cycle while reset is held.
    always_comb begin
        PC_S       = PC_S_RSRC;
        MEM_S      = MEM_S_RDEST;
        WD_S       = WD_IMM;
        ALUA_S     = ALUA_RSRC;
        ALUB_S     = ALUB_RDEST;
        INSTR_EN   = 1'b0;
        ALU_OUT_EN = 1'b0;
        MEM_REG_EN = 1'b0;
        PC_EN      = 1'b0;
        PSR_EN     = 1'b0;
        SE_SIGN    = 1'b0;
        REG_WR     = 1'b0;
        MEM_WE     = 1'b0;
        FORCE_ADD  = 1'b0;
        ILLEGAL    = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: MEM_S = MEM_S_PC;
                S_FETCH_LATCH: begin
                    MEM_S    = MEM_S_PC;
                    INSTR_EN = 1'b1;
                end
                S_EXEC_R: begin
                    ALUA_S     = ALUA_RSRC;
                    ALUB_S     = ALUB_RDEST;
                    ALU_OUT_EN = 1'b1;
                    PSR_EN     = 1'b1;
                end
                S_EXEC_I: begin
                    ALUA_S     = ALUA_IMM;
                    ALUB_S     = ALUB_RDEST;
                    ALU_OUT_EN = 1'b1;
                    PSR_EN     = 1'b1;
                    SE_SIGN    = imm_is_signed(op_code_q);
                end
                S_WB_ALU: begin
                    WD_S   = WD_ALU;
                    REG_WR = 1'b1;
                end
                S_WB_MOV: begin
                    WD_S   = (op_code_q == OP_RTYPE) ? WD_RSRC : WD_IMM;
                    REG_WR = 1'b1;
                end
                S_LD_ADDR: MEM_S = MEM_S_RDEST;
                S_LD_WB: begin
                    MEM_S      = MEM_S_RDEST;
                    MEM_REG_EN = 1'b1;
                    WD_S       = WD_MEM;
                    REG_WR     = 1'b1;
                end
                S_ST: begin
                    MEM_S  = MEM_S_RDEST;
                    MEM_WE = 1'b1;
                end
                S_BR: begin
                    ALUA_S    = ALUA_PC;
                    ALUB_S    = ALUB_IMM;
                    SE_SIGN   = 1'b1;
                    FORCE_ADD = 1'b1;
                    PC_S      = PC_S_ALU;
                    PC_EN     = taken;
                end
                S_JMP: begin
                    PC_S  = PC_S_RSRC;
                    PC_EN = taken;
                end
                S_ILL: ILLEGAL = 1'b1;
                S_PC_INC: begin
                    ALUA_S    = ALUA_PC;
                    ALUB_S    = ALUB_ONE;
                    FORCE_ADD = 1'b1;
                    PC_S      = PC_S_ALU;
                    PC_EN     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_controller.sv
// Directed bench for mcycle_controller: expected per-cycle output vectors are
// queued per instruction and compared cycle by cycle against the DUT.
module tb_mcycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] OP_CODE, OP_EXT, COND;
    logic [4:0] PSR_OUT;
    logic       PC_S, MEM_S, INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN;
    logic       SE_SIGN, REG_WR, MEM_WE, FORCE_ADD, ILLEGAL;
    logic [1:0] WD_S, ALUA_S, ALUB_S;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [17:0] vec;
    } exp_t;
    exp_t sb[$];

    mcycle_controller #(.PSRL(5)) dut (
        .clk(clk), .reset(reset), .OP_CODE(OP_CODE), .OP_EXT(OP_EXT), .COND(COND),
        .PSR_OUT(PSR_OUT), .PC_S(PC_S), .MEM_S(MEM_S), .WD_S(WD_S), .ALUA_S(ALUA_S),
        .ALUB_S(ALUB_S), .INSTR_EN(INSTR_EN), .ALU_OUT_EN(ALU_OUT_EN),
        .MEM_REG_EN(MEM_REG_EN), .PC_EN(PC_EN), .PSR_EN(PSR_EN), .SE_SIGN(SE_SIGN),
        .REG_WR(REG_WR), .MEM_WE(MEM_WE), .FORCE_ADD(FORCE_ADD), .ILLEGAL(ILLEGAL)
    );

    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {PC_S, MEM_S, WD_S, ALUA_S, ALUB_S, INSTR_EN, ALU_OUT_EN, MEM_REG_EN,
                  PC_EN, PSR_EN, SE_SIGN, REG_WR, MEM_WE, FORCE_ADD, ILLEGAL};

    // Packs one expected output set in the same order as obs.
    function automatic logic [17:0] v(
        input logic pc_s, input logic mem_s, input logic [1:0] wd, input logic [1:0] alua,
        input logic [1:0] alub, input logic ien, input logic aen, input logic men,
        input logic pen, input logic psren, input logic se, input logic rw,
        input logic mwe, input logic fadd, input logic ill);
        return {pc_s, mem_s, wd, alua, alub, ien, aen, men, pen, psren, se, rw, mwe, fadd, ill};
    endfunction

    function automatic logic [17:0] e_fetch();   return v(0,1,0,0,0, 0,0,0,0,0, 0,0,0,0,0); endfunction
    function automatic logic [17:0] e_latch();   return v(0,1,0,0,0, 1,0,0,0,0, 0,0,0,0,0); endfunction
    function automatic logic [17:0] e_idle();    return v(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0); endfunction
    function automatic logic [17:0] e_exr();     return v(0,0,0,0,0, 0,1,0,0,1, 0,0,0,0,0); endfunction
    function automatic logic [17:0] e_exi(input logic se); return v(0,0,0,2,0, 0,1,0,0,1, se,0,0,0,0); endfunction
    function automatic logic [17:0] e_wbalu();   return v(0,0,3,0,0, 0,0,0,0,0, 0,1,0,0,0); endfunction
    function automatic logic [17:0] e_wbmov(input logic [1:0] wd); return v(0,0,wd,0,0, 0,0,0,0,0, 0,1,0,0,0); endfunction
    function automatic logic [17:0] e_ldwb();    return v(0,0,2,0,0, 0,0,1,0,0, 0,1,0,0,0); endfunction
    function automatic logic [17:0] e_st();      return v(0,0,0,0,0, 0,0,0,0,0, 0,0,1,0,0); endfunction
    function automatic logic [17:0] e_br(input logic t);  return v(1,0,0,1,1, 0,0,0,t,0, 1,0,0,1,0); endfunction
    function automatic logic [17:0] e_jmp(input logic t); return v(0,0,0,0,0, 0,0,0,t,0, 0,0,0,0,0); endfunction
    function automatic logic [17:0] e_ill();     return v(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,1); endfunction
    function automatic logic [17:0] e_pcinc();   return v(1,0,0,1,2, 0,0,0,1,0, 0,0,0,1,0); endfunction

    task automatic push(input string tag, input logic [17:0] vec);
        exp_t e;
        e.tag = tag;
        e.vec = vec;
        sb.push_back(e);
    endtask

    task automatic instr(input logic [3:0] op, input logic [3:0] ext,
                         input logic [3:0] cnd, input logic [4:0] psr);
        OP_CODE = op;
        OP_EXT  = ext;
        COND    = cnd;
        PSR_OUT = psr;
    endtask

    // Called at a falling edge; checks one queued vector per clock cycle.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            #1;
            e = sb.pop_front();
            checks++;
            assert (obs === e.vec) else begin
                failures++;
                $error("FAIL %s: observed=%05h expected=%05h", e.tag, obs, e.vec);
            end
            $display("check %s obs=%05h exp=%05h", e.tag, obs, e.vec);
            @(negedge clk);
        end
    endtask

    task automatic prefix(input string name);
        push({name, "_fetch"}, e_fetch());
        push({name, "_latch"}, e_latch());
        push({name, "_decode"}, e_idle());
    endtask

    initial begin
        reset = 1'b0;
        instr(4'b0000, 4'b0101, 4'b0000, 5'b00000);
        @(negedge clk);
        repeat (3) push("reset_hold", e_idle());
        drain();
        reset = 1'b1;

        prefix("add");
        push("add_exec", e_exr());
        push("add_wb", e_wbalu());
        push("add_pcinc", e_pcinc());
        drain();

        instr(4'b0100, 4'b0000, 4'b0000, 5'b00000);
        prefix("load");
        push("load_addr", e_idle());
        push("load_wb", e_ldwb());
        push("load_pcinc", e_pcinc());
        drain();

        instr(4'b0100, 4'b0100, 4'b0000, 5'b00000);
        prefix("stor");
        push("stor_st", e_st());
        push("stor_pcinc", e_pcinc());
        drain();

        instr(4'b1100, 4'b0000, 4'b0000, 5'b01000);
        prefix("beq_t");
        push("beq_t_br", e_br(1'b1));
        drain();

        instr(4'b1100, 4'b0000, 4'b0000, 5'b00000);
        prefix("beq_nt");
        push("beq_nt_br", e_br(1'b0));
        push("beq_nt_pcinc", e_pcinc());
        drain();

        instr(4'b1100, 4'b0000, 4'b1111, 5'b11111);
        prefix("bnv");
        push("bnv_br", e_br(1'b0));
        push("bnv_pcinc", e_pcinc());
        drain();

        instr(4'b1011, 4'b0000, 4'b0000, 5'b00000);
        prefix("cmpi");
        push("cmpi_exec", e_exi(1'b1));
        push("cmpi_pcinc", e_pcinc());
        drain();

        instr(4'b0001, 4'b0000, 4'b0000, 5'b00000);
        prefix("andi");
        push("andi_exec", e_exi(1'b0));
        push("andi_wb", e_wbalu());
        push("andi_pcinc", e_pcinc());
        drain();

        instr(4'b0000, 4'b1101, 4'b0000, 5'b00000);
        prefix("mov");
        push("mov_wb", e_wbmov(2'd1));
        push("mov_pcinc", e_pcinc());
        drain();

        instr(4'b0100, 4'b1100, 4'b1110, 5'b00000);
        prefix("juc");
        push("juc_jmp", e_jmp(1'b1));
        drain();

        instr(4'b0100, 4'b1100, 4'b1010, 5'b00010);
        prefix("jlo");
        push("jlo_jmp", e_jmp(1'b0));
        push("jlo_pcinc", e_pcinc());
        drain();

        instr(4'b0111, 4'b0000, 4'b0000, 5'b00000);
        prefix("ill");
        push("ill_ill", e_ill());
        push("ill_pcinc", e_pcinc());
        drain();

        instr(4'b0000, 4'b0101, 4'b0000, 5'b00000);
        prefix("add_rst");
        push("add_rst_exec", e_exr());
        drain();
        reset = 1'b0;
        push("add_rst_wb_abort", e_idle());
        drain();
        reset = 1'b1;

        instr(4'b1101, 4'b0000, 4'b0000, 5'b00000);
        prefix("movi");
        push("movi_wb", e_wbmov(2'd0));
        push("movi_pcinc", e_pcinc());
        push("final_fetch", e_fetch());
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
